tribus_xcvr: RTL and testbench

Bidirectional transceiver for the shared tri-state data bus built from `tribuf`-style drivers. The transmit side arbitrates for the bus, drives one word with a strobe, then releases the bus through a turnaround cycle. The receive side samples words driven by other agents into a small FIFO. One instance sits at each agent attached to the shared bus.

---
 rtl/tribus_xcvr.sv | 168 ++++++++++++++++
 tb/tb_tribus_xcvr.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tribus_xcvr.sv
// -----------------------------------------------------------------------------
// tribus_xcvr
// Transceiver for one agent on a shared tri-state data bus.
//   Transmit: IDLE -> REQ (wait for grant) -> DRIVE (one cycle on the bus with
//   strobe) -> TURN (bus released, one cycle) -> IDLE.
//   Receive: any strobe not produced by this agent pushes the bus word into a
//   small FIFO whose head is presented on rx_data / rx_valid.
//
// Handshakes: tx_valid/tx_ready and rx_valid/rx_ready follow valid/ready rules.
// A word moves only on a rising edge where both are 1. A source holds valid
// and its data stable until that edge, and valid never waits on ready.
//
// Optional feature: define TRIBUS_PARITY_EN to drive even parity on bus_par
// during DRIVE and to flag parity errors on received words (rx_perr).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_data/valid/ready transmit word handshake
//   bus_req, bus_gnt    request to / grant from the external arbiter
//   bus, bus_stb        shared tri-state data and strobe
//   bus_par             shared parity line (driven only with TRIBUS_PARITY_EN)
//   rx_data/valid/ready receive FIFO head handshake
//   rx_ovf              sticky: a received word was dropped on a full FIFO
//   rx_perr             parity error bit of the head word
// -----------------------------------------------------------------------------
module tribus_xcvr #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    inout  wire  [DATA_W-1:0] bus,
    inout  wire               bus_stb,
    inout  wire               bus_par,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_ovf,
    output logic              rx_perr
);

    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } tx_state_t;

    // Current transmit state; kept as a named register so checkers can bind to it.
    tx_state_t         tx_state;
    tx_state_t         tx_state_nxt;
    logic [DATA_W-1:0] tx_word;
    logic              drive_en;

    // ---------------- transmit FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_word  <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == ST_IDLE && tx_valid) begin
                tx_word <= tx_data;
            end
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_ready     = 1'b0;
        bus_req      = 1'b0;
        drive_en     = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) tx_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) tx_state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                bus_req      = 1'b1;
                drive_en     = 1'b1;
                tx_state_nxt = ST_TURN;
            end
            ST_TURN: begin
                tx_state_nxt = ST_IDLE;
            end
            default: tx_state_nxt = ST_IDLE;
        endcase
    end

    // Drivers decode straight from the state register, so an asynchronous
    // reset releases the bus immediately.
    assign bus     = drive_en ? tx_word : {DATA_W{1'bz}};
    assign bus_stb = drive_en ? 1'b1 : 1'bz;

    // ---------------- receive FIFO ----------------
    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              stb_seen;
    logic              pop;
    logic              full;
    logic              push_ok;

    // Only a clean 1 is a strobe; our own DRIVE is never captured.
    assign stb_seen = (bus_stb === 1'b1) && (tx_state != ST_DRIVE);
    assign rx_valid = (count != '0);
    assign pop      = rx_ready && rx_valid;
    assign full     = (count == CW'(RX_DEPTH));
    // A full FIFO still accepts when the head leaves in the same cycle; the
    // write slot then equals the slot being vacated.
    assign push_ok  = stb_seen && (!full || pop);
    assign rx_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rx_ovf <= 1'b0;
            for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= bus;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (stb_seen && !push_ok) rx_ovf <= 1'b1;
        end
    end

`ifdef TRIBUS_PARITY_EN
    logic perr_mem [RX_DEPTH];
    logic perr_in;

    assign bus_par = drive_en ? ^tx_word : 1'bz;
    // X or Z on bus_par never matches, so it is reported as an error.
    assign perr_in = !((^bus) === bus_par);
    assign rx_perr = rx_valid && perr_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_DEPTH; i++) perr_mem[i] <= 1'b0;
        end else if (push_ok) begin
            perr_mem[wr_ptr] <= perr_in;
        end
    end
`else
    logic unused_par;
    assign unused_par = bus_par;
    assign rx_perr    = 1'b0;
`endif

endmodule

// File: tb/tb_tribus_xcvr.sv
// -----------------------------------------------------------------------------
// tb_tribus_xcvr
// Directed bench for tribus_xcvr (DATA_W=8, RX_DEPTH=2). A second bus agent is
// modelled by tri-state drivers on bus / bus_stb / bus_par. All inputs change
// and all outputs are sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tribus_xcvr;

  localparam int W = 8;
`ifdef TRIBUS_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         bus_req;
  logic         bus_gnt;
  wire  [W-1:0] bus;
  wire          bus_stb;
  wire          bus_par;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         rx_ovf;
  logic         rx_perr;

  // external agent
  logic         ext_bus_en, ext_stb_en, ext_par_en;
  logic [W-1:0] ext_data;
  logic         ext_stb, ext_par;

  assign bus     = ext_bus_en ? ext_data : {W{1'bz}};
  assign bus_stb = ext_stb_en ? ext_stb : 1'bz;
  assign bus_par = ext_par_en ? ext_par : 1'bz;

  tribus_xcvr #(.DATA_W(W), .RX_DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .bus      (bus),
    .bus_stb  (bus_stb),
    .bus_par  (bus_par),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_ovf   (rx_ovf),
    .rx_perr  (rx_perr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s", tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_drive(input logic [W-1:0] d, input logic par_en, input logic par);
    ext_bus_en = 1'b1;
    ext_stb_en = 1'b1;
    ext_data   = d;
    ext_stb    = 1'b1;
    ext_par_en = par_en;
    ext_par    = par;
  endtask

  task automatic ext_release();
    ext_bus_en = 1'b0;
    ext_stb_en = 1'b0;
    ext_par_en = 1'b0;
  endtask

  // run-time bound on the whole sequence
  initial begin
    #50000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    bus_gnt  = 1'b0;
    rx_ready = 1'b0;
    ext_data = '0;
    ext_stb  = 1'b0;
    ext_par  = 1'b0;
    ext_release();

    // reset state
    step();
    check("rst_tx_ready", tx_ready === 1'b1);
    check("rst_bus_req", bus_req === 1'b0);
    check("rst_rx_valid", rx_valid === 1'b0);
    check("rst_rx_data", rx_data === 8'h00);
    check("rst_rx_ovf", rx_ovf === 1'b0);
    check("rst_rx_perr", rx_perr === 1'b0);
    check("rst_bus_z", bus === 8'hzz);
    check("rst_stb_z", bus_stb === 1'bz);
    step();
    rst_n = 1'b1;
    step();

    // 1: grant tied high, 3C goes out one cycle after accept
    bus_gnt  = 1'b1;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("t1_req_after_accept", bus_req === 1'b1);
    check("t1_not_ready_req", tx_ready === 1'b0);
    check("t1_bus_z_req", bus === 8'hzz);
    step();
    check("t1_drive_bus", bus === 8'h3C);
    check("t1_drive_stb", bus_stb === 1'b1);
    check("t1_drive_req", bus_req === 1'b1);
`ifdef TRIBUS_PARITY_EN
    check("t1_drive_par", bus_par === 1'b0);
`else
    check("t1_drive_par_z", bus_par === 1'bz);
`endif
    step();
    check("t1_turn_bus_z", bus === 8'hzz);
    check("t1_turn_stb_z", bus_stb === 1'bz);
    check("t1_turn_par_z", bus_par === 1'bz);
    check("t1_turn_req", bus_req === 1'b0);
    check("t1_turn_not_ready", tx_ready === 1'b0);
    check("t1_own_not_captured", rx_valid === 1'b0);
    step();
    check("t1_ready_again", tx_ready === 1'b1);
    check("t1_rx_empty", rx_valid === 1'b0);
    bus_gnt = 1'b0;

    // 2: grant withheld five cycles, tx_data changed after accept
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      check("t2_wait_req", bus_req === 1'b1);
      check("t2_wait_bus_z", bus === 8'hzz);
      check("t2_wait_stb_z", bus_stb === 1'bz);
      step();
    end
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("t2_drive_latched", bus === 8'hA5);
    check("t2_drive_stb", bus_stb === 1'b1);
    step();
    step();
    check("t2_idle_ready", tx_ready === 1'b1);

    // 3: two external words back to back, then two pops
    ext_drive(8'h33, 1'b0, 1'b0);
    step();
    check("t3_first_visible", rx_data === 8'h33);
    check("t3_valid", rx_valid === 1'b1);
    ext_drive(8'hCC, 1'b0, 1'b0);
    step();
    ext_release();
    check("t3_head_33", rx_data === 8'h33);
    rx_ready = 1'b1;
    step();
    check("t3_pop_cc", rx_data === 8'hCC);
    check("t3_pop_valid", rx_valid === 1'b1);
    step();
    check("t3_empty", rx_valid === 1'b0);
    check("t3_no_ovf", rx_ovf === 1'b0);
    rx_ready = 1'b0;

    // 4: overflow on full FIFO, then push with simultaneous pop
    ext_drive(8'h11, 1'b0, 1'b0);
    step();
    ext_drive(8'h22, 1'b0, 1'b0);
    step();
    ext_drive(8'h44, 1'b0, 1'b0);
    step();
    check("t4_ovf_set", rx_ovf === 1'b1);
    check("t4_head_kept", rx_data === 8'h11);
    ext_drive(8'h88, 1'b0, 1'b0);
    rx_ready = 1'b1;
    step();
    ext_release();
    rx_ready = 1'b0;
    check("t4_head_22", rx_data === 8'h22);
    check("t4_ovf_sticky", rx_ovf === 1'b1);
    rx_ready = 1'b1;
    step();
    check("t4_tail_88", rx_data === 8'h88);
    check("t4_tail_valid", rx_valid === 1'b1);
    step();
    check("t4_drained", rx_valid === 1'b0);
    rx_ready = 1'b0;

    // 5: data on the bus with a floating strobe is not a word
    ext_bus_en = 1'b1;
    ext_data   = 8'h77;
    step();
    ext_release();
    check("t5_float_stb_no_push", rx_valid === 1'b0);

    // 6: parity error flag follows the head entry
    ext_drive(8'hC3, 1'b1, 1'b1);
    step();
    ext_drive(8'hC3, 1'b1, 1'b0);
    step();
    ext_release();
    check("t6_bad_head_data", rx_data === 8'hC3);
    check("t6_bad_perr", rx_perr === PAR_ON);
    rx_ready = 1'b1;
    step();
    check("t6_good_perr", rx_perr === 1'b0);
    check("t6_good_valid", rx_valid === 1'b1);
    step();
    check("t6_empty_perr", rx_perr === 1'b0);
    check("t6_empty", rx_valid === 1'b0);
    rx_ready = 1'b0;

    // 7: reset asserted in the middle of DRIVE
    bus_gnt  = 1'b1;
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    check("t7_drive_bus", bus === 8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_bus_z", bus === 8'hzz);
    check("t7_rst_stb_z", bus_stb === 1'bz);
    check("t7_rst_par_z", bus_par === 1'bz);
    check("t7_rst_req", bus_req === 1'b0);
    check("t7_rst_ready", tx_ready === 1'b1);
    check("t7_rst_ovf_clr", rx_ovf === 1'b0);
    bus_gnt = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("t7_post_rst_idle", tx_ready === 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
